// File: rtl/hazard_pkg.sv
// Shared widths, FSM encoding and constants for the hazard controller.
package hazard_pkg;
   localparam int HZ_WORD_LEN     = 32;
   localparam int HZ_REG_ADDR_LEN = 5;

   localparam logic [HZ_REG_ADDR_LEN-1:0] ZERO_REG = '0;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;
endpackage

// File: rtl/hazard_if.sv
// Freeze/flush interface between the hazard controller and the 5-stage pipeline.
interface hazard_if
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_LEN = HZ_REG_ADDR_LEN
);
   logic                    id_valid;
   logic [REG_ADDR_LEN-1:0] id_src1;
   logic [REG_ADDR_LEN-1:0] id_src2;
   logic                    id_two_src;
   logic [REG_ADDR_LEN-1:0] exe_rd;
   logic                    exe_wb_en;
   logic                    exe_mem_read;
   logic                    exe_br_taken;
   logic [REG_ADDR_LEN-1:0] mem_rd;
   logic                    mem_wb_en;
   logic                    dmem_req;
   logic                    dmem_ready;
   logic                    freeze_if;
   logic                    flush_if;
   logic                    bubble_id;
   logic                    freeze_pipe;

   modport master (
      input  id_valid, id_src1, id_src2, id_two_src,
      input  exe_rd, exe_wb_en, exe_mem_read, exe_br_taken,
      input  mem_rd, mem_wb_en, dmem_req, dmem_ready,
      output freeze_if, flush_if, bubble_id, freeze_pipe
   );

   modport slave (
      output id_valid, id_src1, id_src2, id_two_src,
      output exe_rd, exe_wb_en, exe_mem_read, exe_br_taken,
      output mem_rd, mem_wb_en, dmem_req, dmem_ready,
      input  freeze_if, flush_if, bubble_id, freeze_pipe
   );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_LEN = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic [CNT_LEN-1:0] cnt
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + CNT_LEN'(1);
      end
   end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/data stalls, branch flush, data-memory wait,
// plus saturating stall/flush counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int WORD_LEN     = HZ_WORD_LEN,
   parameter int REG_ADDR_LEN = HZ_REG_ADDR_LEN,
   parameter int FORWARD_EN   = 1,
   parameter int CNT_LEN      = 16
) (
   input  logic               clk,
   input  logic               rst,
   hazard_if.master           hif,
   output logic [CNT_LEN-1:0] stall_cnt,
   output logic [CNT_LEN-1:0] flush_cnt
);
   if (CNT_LEN > WORD_LEN) begin : g_cnt_len_check
      $error("CNT_LEN must not exceed WORD_LEN");
   end

   localparam logic [REG_ADDR_LEN-1:0] ZERO = REG_ADDR_LEN'(ZERO_REG);

   state_t state, state_nxt;
   logic   m1_exe, m2_exe, m1_mem, m2_mem;
   logic   hazard, mem_wait;

   always_comb begin
      m1_exe = hif.id_valid && (hif.id_src1 != ZERO) && (hif.id_src1 == hif.exe_rd) && hif.exe_wb_en;
      m2_exe = hif.id_valid && hif.id_two_src && (hif.id_src2 != ZERO) &&
               (hif.id_src2 == hif.exe_rd) && hif.exe_wb_en;
      m1_mem = hif.id_valid && (hif.id_src1 != ZERO) && (hif.id_src1 == hif.mem_rd) && hif.mem_wb_en;
      m2_mem = hif.id_valid && hif.id_two_src && (hif.id_src2 != ZERO) &&
               (hif.id_src2 == hif.mem_rd) && hif.mem_wb_en;
      if (FORWARD_EN != 0) hazard = (m1_exe || m2_exe) && hif.exe_mem_read;
      else                 hazard = m1_exe || m2_exe || m1_mem || m2_mem;
   end

   // Wait covers the request cycle itself and every cycle until ready.
   always_comb begin
      state_nxt = state;
      mem_wait  = 1'b0;
      case (state)
         RUN: begin
            if (hif.dmem_req && !hif.dmem_ready) begin
               mem_wait  = 1'b1;
               state_nxt = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (hif.dmem_ready) state_nxt = RUN;
            else                mem_wait  = 1'b1;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RUN;
      else      state <= state_nxt;
   end

   always_comb begin
      hif.freeze_if   = 1'b0;
      hif.flush_if    = 1'b0;
      hif.bubble_id   = 1'b0;
      hif.freeze_pipe = 1'b0;
      if (rst) begin
         if (mem_wait) begin
            hif.freeze_if   = 1'b1;
            hif.freeze_pipe = 1'b1;
         end else if (hif.exe_br_taken) begin
            hif.flush_if  = 1'b1;
            hif.bubble_id = 1'b1;
         end else if (hazard) begin
            hif.freeze_if = 1'b1;
            hif.bubble_id = 1'b1;
         end
      end
   end

   sat_counter #(.CNT_LEN(CNT_LEN)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .en  (hif.freeze_if),
      .cnt (stall_cnt)
   );

   sat_counter #(.CNT_LEN(CNT_LEN)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .en  (hif.flush_if),
      .cnt (flush_cnt)
   );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: one DUT with forwarding, one without, driven from the same stimulus.
module tb_hazard_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       id_valid, id_two_src, exe_wb_en, exe_mem_read, exe_br_taken;
   logic       mem_wb_en, dmem_req, dmem_ready;
   logic [4:0] id_src1, id_src2, exe_rd, mem_rd;
   logic [15:0] stall_f, flush_f, stall_n, flush_n;
   int compared = 0;
   int mismatched = 0;

   hazard_if #(.REG_ADDR_LEN(5)) if_f ();
   hazard_if #(.REG_ADDR_LEN(5)) if_n ();

   assign if_f.id_valid = id_valid;         assign if_n.id_valid = id_valid;
   assign if_f.id_src1 = id_src1;           assign if_n.id_src1 = id_src1;
   assign if_f.id_src2 = id_src2;           assign if_n.id_src2 = id_src2;
   assign if_f.id_two_src = id_two_src;     assign if_n.id_two_src = id_two_src;
   assign if_f.exe_rd = exe_rd;             assign if_n.exe_rd = exe_rd;
   assign if_f.exe_wb_en = exe_wb_en;       assign if_n.exe_wb_en = exe_wb_en;
   assign if_f.exe_mem_read = exe_mem_read; assign if_n.exe_mem_read = exe_mem_read;
   assign if_f.exe_br_taken = exe_br_taken; assign if_n.exe_br_taken = exe_br_taken;
   assign if_f.mem_rd = mem_rd;             assign if_n.mem_rd = mem_rd;
   assign if_f.mem_wb_en = mem_wb_en;       assign if_n.mem_wb_en = mem_wb_en;
   assign if_f.dmem_req = dmem_req;         assign if_n.dmem_req = dmem_req;
   assign if_f.dmem_ready = dmem_ready;     assign if_n.dmem_ready = dmem_ready;

   hazard_ctrl #(.FORWARD_EN(1), .CNT_LEN(16)) u_fwd (
      .clk(clk), .rst(rst), .hif(if_f), .stall_cnt(stall_f), .flush_cnt(flush_f));
   hazard_ctrl #(.FORWARD_EN(0), .CNT_LEN(16)) u_nof (
      .clk(clk), .rst(rst), .hif(if_n), .stall_cnt(stall_n), .flush_cnt(flush_n));

   always #5 clk = ~clk;

   task automatic idle();
      id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
      exe_rd = 0; exe_wb_en = 0; exe_mem_read = 0; exe_br_taken = 0;
      mem_rd = 0; mem_wb_en = 0; dmem_req = 0; dmem_ready = 0;
   endtask

   task automatic reset_pulse();
      @(negedge clk); idle(); rst = 0;
      @(negedge clk); rst = 1;
   endtask

   task automatic test_reset();
      @(negedge clk); rst = 1; idle(); dmem_req = 1; dmem_ready = 0;
      @(negedge clk); @(negedge clk); #1;
      compared++; if (stall_f !== 16'd2) begin mismatched++; $display("FAIL rst_pre_stall: got %0d want 2", stall_f); end
      rst = 0; #1;
      compared++; if (if_f.freeze_if !== 1'b0) begin mismatched++; $display("FAIL rst_freeze_if: got %b want 0", if_f.freeze_if); end
      compared++; if (if_f.freeze_pipe !== 1'b0) begin mismatched++; $display("FAIL rst_freeze_pipe: got %b want 0", if_f.freeze_pipe); end
      compared++; if (stall_f !== 16'd0) begin mismatched++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_f); end
      compared++; if (flush_f !== 16'd0 || flush_n !== 16'd0) begin mismatched++; $display("FAIL rst_flush_cnt: got %0d/%0d want 0", flush_f, flush_n); end
      @(negedge clk); dmem_req = 0; rst = 1; #1;
      compared++; if (if_f.freeze_if !== 1'b0) begin mismatched++; $display("FAIL rst_state_run: got %b want 0", if_f.freeze_if); end
   endtask

   task automatic test_load_use();
      reset_pulse();
      exe_rd = 3; exe_wb_en = 1; exe_mem_read = 1; id_valid = 1; id_src1 = 3; #1;
      compared++; if ({if_f.freeze_if, if_f.bubble_id, if_f.flush_if, if_f.freeze_pipe} !== 4'b1100) begin
         mismatched++; $display("FAIL lu_stall: got %b want 1100", {if_f.freeze_if, if_f.bubble_id, if_f.flush_if, if_f.freeze_pipe}); end
      @(negedge clk); exe_rd = 0; exe_wb_en = 0; exe_mem_read = 0; mem_rd = 3; mem_wb_en = 1; #1;
      compared++; if (if_f.freeze_if !== 1'b0) begin mismatched++; $display("FAIL lu_release: got %b want 0", if_f.freeze_if); end
      @(negedge clk); #1;
      compared++; if (stall_f !== 16'd1) begin mismatched++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_f); end
      idle(); id_valid = 1; id_src1 = 0; exe_rd = 0; exe_wb_en = 1; exe_mem_read = 1; #1;
      compared++; if (if_f.freeze_if !== 1'b0) begin mismatched++; $display("FAIL lu_zero_reg: got %b want 0", if_f.freeze_if); end
      id_src1 = 7; id_src2 = 4; id_two_src = 1; exe_rd = 4; #1;
      compared++; if (if_f.freeze_if !== 1'b1) begin mismatched++; $display("FAIL lu_src2: got %b want 1", if_f.freeze_if); end
      id_valid = 0; #1;
      compared++; if (if_f.freeze_if !== 1'b0) begin mismatched++; $display("FAIL lu_invalid: got %b want 0", if_f.freeze_if); end
   endtask

   task automatic test_no_forward();
      reset_pulse();
      exe_rd = 5; exe_wb_en = 1; id_valid = 1; id_src1 = 5; #1;
      compared++; if ({if_n.freeze_if, if_n.bubble_id} !== 2'b11) begin mismatched++; $display("FAIL nf_stall1: got %b want 11", {if_n.freeze_if, if_n.bubble_id}); end
      compared++; if (if_f.freeze_if !== 1'b0) begin mismatched++; $display("FAIL nf_fwd_nostall: got %b want 0", if_f.freeze_if); end
      @(negedge clk); exe_rd = 0; exe_wb_en = 0; mem_rd = 5; mem_wb_en = 1; #1;
      compared++; if (if_n.freeze_if !== 1'b1) begin mismatched++; $display("FAIL nf_stall2: got %b want 1", if_n.freeze_if); end
      @(negedge clk); mem_rd = 0; mem_wb_en = 0; #1;
      compared++; if (if_n.freeze_if !== 1'b0) begin mismatched++; $display("FAIL nf_release: got %b want 0", if_n.freeze_if); end
      @(negedge clk); #1;
      compared++; if (stall_n !== 16'd2) begin mismatched++; $display("FAIL nf_stall_cnt: got %0d want 2", stall_n); end
      id_src1 = 1; id_src2 = 5; id_two_src = 0; exe_rd = 5; exe_wb_en = 1; #1;
      compared++; if (if_n.freeze_if !== 1'b0) begin mismatched++; $display("FAIL nf_no_src2: got %b want 0", if_n.freeze_if); end
   endtask

   task automatic test_branch();
      reset_pulse();
      exe_rd = 3; exe_wb_en = 1; exe_mem_read = 1; id_valid = 1; id_src1 = 3; exe_br_taken = 1; #1;
      compared++; if ({if_f.flush_if, if_f.bubble_id, if_f.freeze_if, if_f.freeze_pipe} !== 4'b1100) begin
         mismatched++; $display("FAIL br_flush: got %b want 1100", {if_f.flush_if, if_f.bubble_id, if_f.freeze_if, if_f.freeze_pipe}); end
      @(negedge clk); idle(); #1;
      compared++; if (if_f.flush_if !== 1'b0) begin mismatched++; $display("FAIL br_release: got %b want 0", if_f.flush_if); end
      compared++; if (flush_f !== 16'd1 || stall_f !== 16'd0) begin mismatched++; $display("FAIL br_cnts: got %0d/%0d want 1/0", flush_f, stall_f); end
   endtask

   task automatic test_mem_wait();
      reset_pulse();
      exe_br_taken = 1; dmem_req = 1; dmem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         compared++; if ({if_f.freeze_if, if_f.freeze_pipe, if_f.flush_if, if_f.bubble_id} !== 4'b1100) begin
            mismatched++; $display("FAIL mw_wait%0d: got %b want 1100", i, {if_f.freeze_if, if_f.freeze_pipe, if_f.flush_if, if_f.bubble_id}); end
         @(negedge clk);
      end
      dmem_ready = 1; #1;
      compared++; if ({if_f.freeze_if, if_f.freeze_pipe, if_f.flush_if, if_f.bubble_id} !== 4'b0011) begin
         mismatched++; $display("FAIL mw_ready: got %b want 0011", {if_f.freeze_if, if_f.freeze_pipe, if_f.flush_if, if_f.bubble_id}); end
      @(negedge clk); exe_br_taken = 0; dmem_req = 1; dmem_ready = 1; #1;
      compared++; if ({if_f.freeze_if, if_f.freeze_pipe} !== 2'b00) begin mismatched++; $display("FAIL mw_same_cycle: got %b want 00", {if_f.freeze_if, if_f.freeze_pipe}); end
      @(negedge clk); idle(); #1;
      compared++; if (stall_f !== 16'd3 || flush_f !== 16'd1) begin mismatched++; $display("FAIL mw_cnts: got %0d/%0d want 3/1", stall_f, flush_f); end
   endtask

   task automatic test_saturation();
      reset_pulse();
      dmem_req = 1; dmem_ready = 0;
      repeat (65541) @(posedge clk);
      #1;
      compared++; if (stall_f !== 16'hFFFF) begin mismatched++; $display("FAIL sat_stall: got %h want ffff", stall_f); end
      compared++; if (flush_f !== 16'h0000) begin mismatched++; $display("FAIL sat_flush: got %h want 0000", flush_f); end
      @(negedge clk); dmem_ready = 1; #1;
      compared++; if (if_f.freeze_if !== 1'b0) begin mismatched++; $display("FAIL sat_ready: got %b want 0", if_f.freeze_if); end
      @(negedge clk); idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_load_use();
      test_no_forward();
      test_branch();
      test_mem_wait();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
